// File: rtl/priority_encoder_seq.sv
// priority_encoder_seq: drains each accepted 16-bit request vector as one 4-bit index per set bit.
// Define PRIORITY_ENCODER_SEQ_ZERO_FLAG_EN to emit a flagged beat (out_zero) for an all-zero vector.
module priority_encoder_seq #(
   parameter int MSB_FIRST = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out,
   output logic        out_last,
   output logic        busy
`ifdef PRIORITY_ENCODER_SEQ_ZERO_FLAG_EN
   ,
   output logic        out_zero
`endif
);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t      state_q, state_d;
   logic [15:0] pend_q, pend_d;
   logic [3:0]  idx;
   logic        emit, accept;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   // the last matching bit in scan order wins, so scan toward the preferred end
   always_comb begin
      idx = '0;
      for (int i = 0; i < 16; i++)
         if (pend_q[MSB_FIRST != 0 ? i : 15 - i]) idx = MSB_FIRST != 0 ? 4'(i) : 4'(15 - i);
   end
   assign emit      = state_q == EMIT;
   assign busy      = emit;
   assign out_valid = emit;
   assign in_ready  = !emit;
   assign out       = emit ? idx : '0;
   // an empty pending register in EMIT is the flagged zero beat, which is also last
   assign out_last  = emit && ((pend_q & (pend_q - 16'd1)) == '0);
`ifdef PRIORITY_ENCODER_SEQ_ZERO_FLAG_EN
   assign out_zero  = emit && pend_q == '0;
   assign accept    = in_valid;
`else
   assign accept    = in_valid && in != '0;
`endif
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      if (!emit) begin
         state_d = accept ? EMIT : IDLE;
         pend_d  = accept ? in : pend_q;
      end else if (out_ready) begin
         pend_d  = pend_q & ~(16'd1 << idx);
         state_d = out_last ? IDLE : EMIT;
      end
   end
endmodule
